multiplier_digit_serial_ctrl: RTL and testbench
===============================================

// Module: multiplier_digit_serial_ctrl
// PURPOSE
//   Sequences a WIDTH x WIDTH unsigned multiply as radix-4 shift-add: one 2-bit multiplier digit per cycle.
//   Each cycle the datapath forms the digit x multiplicand partial product from 2-bit multiplier cells,
//   adds it into an accumulator and shifts. The controller owns the operand and accumulator registers,
//   the digit counter and the valid/ready handshakes on both sides.
//   Sits between an operand source and a result consumer, in place of a full combinational array.
// PARAMETERS
//   WIDTH     4    operand width in bits; must be even and >= 2; product is 2*WIDTH bits
//   CNT_W     $clog2(WIDTH/2)+1   digit-counter width (derived, do not override)
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        operand pair offered
//   in_ready   out  1        controller accepts operands this cycle
//   num1       in   WIDTH    multiplicand
//   num2       in   WIDTH    multiplier (consumed 2 bits per cycle, LSB digit first)
//   out_valid  out  1        product is valid and held
//   out_ready  in   1        consumer takes product this cycle
//   product    out  2*WIDTH  num1 * num2, unsigned
//   busy       out  1        high while a multiply is in progress (state BUSY)
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, counter=0, regs=0.
//   FSM: IDLE -> BUSY on in_valid&in_ready; BUSY -> DONE when counter reaches WIDTH/2-1;
//        DONE -> IDLE on out_ready (out_valid&out_ready).
//   IDLE: in_ready=1. Accept edge captures mcand<=num1, mplier<=num2, acc<=0, counter<=0.
//   BUSY: each cycle, pp = mplier[1:0] * mcand (WIDTH+2 bits).
//         acc <= acc + (pp << 2*counter); mplier >>= 2; counter++.
//         Add is 2*WIDTH bits wide; the final sum never overflows 2*WIDTH.
//   DONE: out_valid=1, product=acc held stable until accepted; in_ready=0.
//   Latency: accept at edge N -> out_valid high after edge N+WIDTH/2 (WIDTH=4: 2 BUSY cycles).
//   Throughput: one result per WIDTH/2+2 cycles without backpressure.
//   Boundaries:
//     - in_ready is 0 in BUSY and DONE; in_valid there is ignored, inputs are not sampled.
//     - No early termination on zero digits; cycle count is fixed and data-independent.
//     - out_ready held low: stay in DONE indefinitely, product unchanged.
//     - in_valid in the same cycle as out_ready in DONE: not accepted; the accept occurs on the
//       following IDLE cycle (no combinational in_ready<-out_ready path).
//     - product keeps the last result after DONE->IDLE; it is valid only while out_valid=1.
//     - rst asserted mid-BUSY or in DONE: operation is abandoned, outputs return to reset values,
//       and no out_valid pulse is produced for the aborted operands.
//     - num1/num2 changing after the accept edge has no effect on the result.
// STRUCTURE
//   Shared package: state encoding localparams (ST_IDLE=2'd0, ST_BUSY=2'd1, ST_DONE=2'd2), DIGIT_W=2.
//   One sub-module: multiplier_2xn_partial, a combinational 2-bit x WIDTH-bit partial-product generator
//   built from and-gates and adder_half/full-adder cells (gate-level, same style as the existing 2x2 cell).
//   The controller holds the FSM, counter, shift/accumulate registers and handshakes; no other hierarchy.
// TESTING (WIDTH=4 unless noted)
//   1. rst pulse, then 3x3 with out_ready=1 -> busy for 2 cycles; out_valid with product=8'd9; back to IDLE.
//   2. 15x15 -> product=8'd225; 0x13 -> 8'd0; 13x0 -> 8'd0; exhaustive 16x16 sweep matches num1*num2.
//   3. Backpressure: 10x11, out_ready=0 for 5 cycles -> out_valid stays 1, product=8'd110 stable,
//      in_ready=0; new in_valid during that time is not accepted.
//   4. Back-to-back: in_valid held high with 2x3, then 7x9 -> results 6 then 63 in order, each
//      accept edge 4 cycles apart.
//   5. Async rst asserted mid-BUSY during 12x12 (between clock edges) -> out_valid=0, in_ready=1 at once;
//      no 144 result appears; the next 5x5 yields 25.
//   6. WIDTH=8: 255x255 -> 16'd65025 after 4 BUSY cycles; 128x2 -> 16'd256.

Source files
------------

// File: rtl/multiplier_digit_serial_ctrl_pkg.sv
// Shared definitions for the digit-serial (radix-4) multiplier controller.
// State encodings and digit width used by the controller and the partial-product cell.
package multiplier_digit_serial_ctrl_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam int         DIGIT_W = 2;
endpackage

// File: rtl/multiplier_digit_serial_ctrl_partial.sv
// Combinational 2-bit x WIDTH-bit partial-product generator.
// AND-gate rows for each digit bit, summed by a gate-level ripple of full-adder cells.
import multiplier_digit_serial_ctrl_pkg::*;

module multiplier_2xn_partial #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0]   mcand,
   input  logic [DIGIT_W-1:0] digit,
   output logic [WIDTH+1:0]   pp
);
   logic [WIDTH:0]   row0;
   logic [WIDTH:0]   row1;
   logic [WIDTH+1:0] carry;

   // row1 is pre-shifted by one: digit bit 1 has weight 2
   assign row0     = {1'b0, mcand & {WIDTH{digit[0]}}};
   assign row1     = {mcand & {WIDTH{digit[1]}}, 1'b0};
   assign carry[0] = 1'b0;

   for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
      assign pp[i]      = row0[i] ^ row1[i] ^ carry[i];
      assign carry[i+1] = (row0[i] & row1[i]) | (carry[i] & (row0[i] ^ row1[i]));
   end

   assign pp[WIDTH+1] = carry[WIDTH+1];
endmodule

// File: rtl/multiplier_digit_serial_ctrl.sv
// Radix-4 shift-add multiply sequencer: one multiplier digit per cycle, fixed WIDTH/2 cycles.
// Owns operand/accumulator registers, digit counter and both valid/ready handshakes.
import multiplier_digit_serial_ctrl_pkg::*;

module multiplier_digit_serial_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     num1,
   input  logic [WIDTH-1:0]     num2,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);
   logic [1:0]         state;
   logic [1:0]         state_next;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mplier;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] pp_ext;
   logic [2*WIDTH-1:0] acc_sum;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH+1:0]   pp;
   logic               last_digit;
   logic               accept;

   multiplier_2xn_partial #(.WIDTH(WIDTH)) u_partial (
      .mcand (mcand),
      .digit (mplier[DIGIT_W-1:0]),
      .pp    (pp)
   );

   assign pp_ext     = (2*WIDTH)'(pp);
   assign acc_sum    = acc + (pp_ext << {cnt, 1'b0});
   assign last_digit = (cnt == CNT_W'(WIDTH/2 - 1));
   assign accept     = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (in_valid)   state_next = ST_BUSY;
         ST_BUSY: if (last_digit) state_next = ST_DONE;
         ST_DONE: if (out_ready)  state_next = ST_IDLE;
         default:                 state_next = ST_IDLE;
      endcase
   end

   // Registered-state decode only: in_ready never depends on out_ready
   always_comb begin
      in_ready  = (state == ST_IDLE);
      busy      = (state == ST_BUSY);
      out_valid = (state == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         product <= '0;
      end else if (accept) begin
         mcand  <= num1;
         mplier <= num2;
         acc    <= '0;
         cnt    <= '0;
      end else if (state == ST_BUSY) begin
         acc    <= acc_sum;
         mplier <= mplier >> DIGIT_W;
         cnt    <= cnt + CNT_W'(1);
         // product is a separate register so it survives the next accept clearing acc
         if (last_digit) product <= acc_sum;
      end
   end
endmodule

// File: tb/tb_multiplier_digit_serial_ctrl.sv
// Directed + randomized bench for the digit-serial multiplier (WIDTH=4 and WIDTH=8 instances).
// Expected products and latencies come from plain arithmetic on the operands.
module tb_multiplier_digit_serial_ctrl;
   logic       clk;
   logic       rst;
   logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
   logic [3:0] num1_4, num2_4;
   logic [7:0] product4;
   logic       in_valid8, in_ready8, out_valid8, out_ready8, busy8;
   logic [7:0] num1_8, num2_8;
   logic [15:0] product8;

   int total;
   int bad;

   multiplier_digit_serial_ctrl #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .num1(num1_4), .num2(num2_4), .out_valid(out_valid4), .out_ready(out_ready4),
      .product(product4), .busy(busy4)
   );

   multiplier_digit_serial_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .num1(num1_8), .num2(num2_8), .out_valid(out_valid8), .out_ready(out_ready8),
      .product(product8), .busy(busy8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One full transaction on the WIDTH=4 instance; model: product = a*b after 2 BUSY cycles
   task automatic mul4(input logic [3:0] a, input logic [3:0] b, input string tag);
      int n;
      n = 0;
      while (!in_ready4 && n < 20) begin @(posedge clk); #1; n++; end
      check({tag, ".in_ready"}, 32'(in_ready4), 32'd1);
      in_valid4 = 1'b1; num1_4 = a; num2_4 = b;
      @(posedge clk); #1;
      in_valid4 = 1'b0; num1_4 = 4'($urandom); num2_4 = 4'($urandom);
      check({tag, ".busy"}, 32'(busy4), 32'd1);
      n = 0;
      while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
      check({tag, ".latency"}, 32'(n), 32'd2);
      check({tag, ".product"}, 32'(product4), 32'(a) * 32'(b));
      check({tag, ".rdy_done"}, 32'(in_ready4), 32'd0);
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      check({tag, ".idle"}, {30'd0, out_valid4, in_ready4}, 32'd1);
   endtask

   task automatic mul8(input logic [7:0] a, input logic [7:0] b, input string tag);
      int n;
      n = 0;
      while (!in_ready8 && n < 20) begin @(posedge clk); #1; n++; end
      check({tag, ".in_ready"}, 32'(in_ready8), 32'd1);
      in_valid8 = 1'b1; num1_8 = a; num2_8 = b;
      @(posedge clk); #1;
      in_valid8 = 1'b0; num1_8 = 8'($urandom); num2_8 = 8'($urandom);
      n = 0;
      while (!out_valid8 && n < 20) begin @(posedge clk); #1; n++; end
      check({tag, ".latency"}, 32'(n), 32'd4);
      check({tag, ".product"}, 32'(product8), 32'(a) * 32'(b));
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      check({tag, ".idle"}, {30'd0, out_valid8, in_ready8}, 32'd1);
   endtask

   initial begin
      int n;
      int cyc;
      logic fire, ov, seen;
      logic [7:0] pr;
      int edges[$];
      logic [7:0] results[$];

      total = 0; bad = 0;
      rst = 1'b1;
      in_valid4 = 0; out_ready4 = 0; num1_4 = 0; num2_4 = 0;
      in_valid8 = 0; out_ready8 = 0; num1_8 = 0; num2_8 = 0;

      #12;
      check("reset.in_ready", 32'(in_ready4), 32'd1);
      check("reset.out_valid", 32'(out_valid4), 32'd0);
      check("reset.busy", 32'(busy4), 32'd0);
      check("reset.product", 32'(product4), 32'd0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // directed corners
      mul4(4'd3, 4'd3, "t1_3x3");
      mul4(4'd15, 4'd15, "t2_15x15");
      mul4(4'd0, 4'd13, "t2_0x13");
      mul4(4'd13, 4'd0, "t2_13x0");

      // backpressure: result held, new offers ignored
      in_valid4 = 1'b1; num1_4 = 4'd10; num2_4 = 4'd11;
      @(posedge clk); #1;
      num1_4 = 4'd1; num2_4 = 4'd1;
      n = 0;
      while (!out_valid4 && n < 20) begin @(posedge clk); #1; n++; end
      check("t3.latency", 32'(n), 32'd2);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("t3.hold_valid", 32'(out_valid4), 32'd1);
         check("t3.hold_product", 32'(product4), 32'd110);
         check("t3.hold_in_ready", 32'(in_ready4), 32'd0);
      end
      in_valid4 = 1'b0; out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      check("t3.release_in_ready", 32'(in_ready4), 32'd1);
      check("t3.product_kept", 32'(product4), 32'd110);

      // back-to-back with in_valid held; accept edges 4 cycles apart
      in_valid4 = 1'b1; num1_4 = 4'd2; num2_4 = 4'd3; out_ready4 = 1'b1;
      cyc = 0;
      while (cyc < 30 && results.size() < 2) begin
         fire = in_valid4 && in_ready4;
         ov   = out_valid4;
         pr   = product4;
         @(posedge clk); #1; cyc++;
         if (fire) begin
            edges.push_back(cyc);
            if (edges.size() == 1) begin num1_4 = 4'd7; num2_4 = 4'd9; end
            else in_valid4 = 1'b0;
         end
         if (ov) results.push_back(pr);
      end
      in_valid4 = 1'b0; out_ready4 = 1'b0;
      check("t4.nresults", 32'(results.size()), 32'd2);
      check("t4.naccepts", 32'(edges.size()), 32'd2);
      if (results.size() == 2) begin
         check("t4.first", 32'(results[0]), 32'd6);
         check("t4.second", 32'(results[1]), 32'd63);
      end
      if (edges.size() == 2) check("t4.spacing", 32'(edges[1] - edges[0]), 32'd4);

      // async reset mid-BUSY abandons the operation
      in_valid4 = 1'b1; num1_4 = 4'd12; num2_4 = 4'd12;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      check("t5.busy", 32'(busy4), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t5.out_valid", 32'(out_valid4), 32'd0);
      check("t5.in_ready", 32'(in_ready4), 32'd1);
      check("t5.busy_clr", 32'(busy4), 32'd0);
      check("t5.product_clr", 32'(product4), 32'd0);
      #2 rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (out_valid4) seen = 1'b1;
      end
      check("t5.no_result", 32'(seen), 32'd0);
      mul4(4'd5, 4'd5, "t5_5x5");

      // randomized operands against arithmetic reference
      for (int i = 0; i < 20; i++) mul4(4'($urandom), 4'($urandom), "rand4");

      // exhaustive WIDTH=4 sweep
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            mul4(4'(a), 4'(b), "sweep");

      // WIDTH=8 instance
      mul8(8'd255, 8'd255, "t6_255x255");
      mul8(8'd128, 8'd2, "t6_128x2");
      for (int i = 0; i < 10; i++) mul8(8'($urandom), 8'($urandom), "rand8");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
